// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring
// shift-subtract step per cycle.  FSM: IDLE -> CALC (32 steps) -> FIX -> DONE.
// Optional feature macro: DIV_FAST_SPECIAL_EN -- divide-by-zero and signed
// overflow skip the iteration and finish straight from the accepting edge.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] q, d, rem, a_org;
    logic [1:0]      op_r;
    logic            neg_q, neg_r, div_zero, ovf;

    // operand conditioning for the accepting edge
    logic            a_neg, b_neg, in_zero, in_ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag;

    // one restoring step (33-bit unsigned subtract, borrow in the top bit)
    logic [XLEN:0]   rem33, diff;
    logic            borrow;

    // sign fix-up and special-case override
    logic [XLEN-1:0] q_fix, r_fix, fix_res;
`ifdef DIV_FAST_SPECIAL_EN
    logic [XLEN-1:0] fast_res;
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // DONE is the last busy cycle; a start there is taken on the edge leaving it
    assign accept  = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
    assign a_neg   = op[0] & a[XLEN-1];
    assign b_neg   = op[0] & b[XLEN-1];
    // magnitude of the most negative value stays 0x80000000 as unsigned
    assign a_mag   = a_neg ? (~a + 1'b1) : a;
    assign b_mag   = b_neg ? (~b + 1'b1) : b;
    assign in_zero = (b == '0);
    assign in_ovf  = op[0] & (a == MIN_NEG) & (b == ALL_ONE);

    assign rem33   = {rem, q[XLEN-1]};
    assign diff    = rem33 - {1'b0, d};
    assign borrow  = diff[XLEN];

    // final quotient/remainder with RV32M special values forced over the datapath
    always_comb begin
        q_fix = neg_q ? (~q + 1'b1) : q;
        r_fix = neg_r ? (~rem + 1'b1) : rem;
        if (div_zero) begin
            q_fix = ALL_ONE;
            r_fix = a_org;
        end else if (ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        fix_res = op_r[1] ? r_fix : q_fix;
    end

`ifdef DIV_FAST_SPECIAL_EN
    // special-case result straight from the request operands
    always_comb begin
        if (in_zero) fast_res = op[1] ? a : ALL_ONE;
        else         fast_res = op[1] ? '0 : MIN_NEG;
    end
`endif

    // FSM, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            q        <= '0;
            d        <= '0;
            rem      <= '0;
            a_org    <= '0;
            op_r     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_r     <= op;
                        a_org    <= a;
                        q        <= a_mag;
                        d        <= b_mag;
                        rem      <= '0;
                        cnt      <= CNT_W'(XLEN - 1);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= in_zero;
                        ovf      <= in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
                        if (in_zero || in_ovf) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
`else
                        state    <= S_CALC;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (borrow) begin
                        rem <= rem33[XLEN-1:0];
                        q   <= {q[XLEN-2:0], 1'b0};
                    end else begin
                        rem <= diff[XLEN-1:0];
                        q   <= {q[XLEN-2:0], 1'b1};
                    end
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                S_FIX: begin
                    result <= fix_res;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.  Expected results and latencies
// come from a behavioural RV32M model and are queued when a request is driven;
// the monitor pops and compares them whenever done pulses.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic [31:0] qq, rr;
        sx = x; sy = y;
        if (y == 0) begin
            qq = 32'hFFFF_FFFF; rr = x;
        end else if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            qq = 32'h8000_0000; rr = 0;
        end else if (o[0]) begin
            qq = sx / sy; rr = sx % sy;
        end else begin
            qq = x / y; rr = x % y;
        end
        return o[1] ? rr : qq;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FAST_SPECIAL_EN
        if (y == 0 || (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
        return 34;
    endfunction

    // monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                last_res = e.res;
            end
        end
    end

    // drive one request (start held for one edge) and queue its expectation
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
        exp_t e;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (track) begin
            e.res = ref_div(o, x, y);
            e.lat = ref_lat(o, x, y);
            e.t0  = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, 1'b1);
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        last_res = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run(2'b00, 32'd100, 32'd7);
        run(2'b10, 32'd100, 32'd7);
        run(2'b01, 32'hFFFF_FFF9, 32'd2);
        run(2'b11, 32'hFFFF_FFF9, 32'd2);
        run(2'b00, 32'd5, 32'd0);
        run(2'b10, 32'd5, 32'd0);
        run(2'b01, 32'hFFFF_FFFB, 32'd0);
        run(2'b11, 32'hFFFF_FFFB, 32'd0);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b01, 32'h8000_0000, 32'd3);
        run(2'b11, 32'd7, 32'hFFFF_FFFE);

        // random mix of all four ops
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run(2'($urandom_range(0, 3)), x, y);
        end

        // flush mid-operation: no done, result untouched
        issue(2'b00, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", result, last_res);
        repeat (40) @(negedge clk);
        chk("flush_hold", result, last_res);
        run(2'b00, 32'd9, 32'd3);

        // flush together with start: nothing starts
        @(negedge clk);
        op = 2'b00; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // start pulses while busy are ignored
        issue(2'b00, 32'd1000, 32'd10, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            op = 2'b11; a = 32'd77 + 32'(i); b = 32'd4; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        chk("busy_mid", {31'd0, busy}, 32'd1);
        wait_drain();

        // asynchronous reset mid-CALC
        issue(2'b00, 32'd12345, 32'd11, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_idle", {31'd0, busy}, 32'd0);
        run(2'b10, 32'd12345, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
